mult_div_unit: RTL and testbench

//  Iterative MIPS HI/LO multiply/divide unit, directly downstream of the register file.

---
 rtl/mult_div_unit.sv | 199 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Optional macro MDU_SIGNED_EN enables signed MULT/DIV on op_i[1]; undefined builds are unsigned only.
module mult_div_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic [1:0]   op_i,
    input  logic [N-1:0] rs_data_i,
    input  logic [N-1:0] rt_data_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         div_by_zero_o,
    output logic [N-1:0] hi_o,
    output logic [N-1:0] lo_o
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            is_div_q, is_div_d;
    logic [N:0]      acc_q, acc_d;
    logic [N-1:0]    q_q, q_d;
    logic [N-1:0]    b_q, b_d;
    logic [N-1:0]    dvd_q, dvd_d;
    logic [N-1:0]    hi_q, hi_d;
    logic [N-1:0]    lo_q, lo_d;
    logic            dbz_q, dbz_d;

    logic [N-1:0]    mag_a, mag_b;
    logic [N:0]      mul_sum, div_shift, div_diff, step_acc;
    logic [N-1:0]    step_q;
    logic [2*N-1:0]  prod;
    logic [N-1:0]    res_hi, res_lo;
    logic            res_dbz;

`ifdef MDU_SIGNED_EN
    logic            sign_a, sign_b;
    logic            neg_q, neg_d, negr_q, negr_d;

    assign sign_a = op_i[1] & rs_data_i[N-1];
    assign sign_b = op_i[1] & rt_data_i[N-1];
    assign mag_a  = sign_a ? -rs_data_i : rs_data_i;
    assign mag_b  = sign_b ? -rt_data_i : rt_data_i;
`else
    logic            unused_op;

    assign unused_op = op_i[1];
    assign mag_a     = rs_data_i;
    assign mag_b     = rt_data_i;
`endif

    // One iteration: {acc,q} is the shifting product, or {remainder,dividend/quotient}.
    // While the invariant remainder < divisor holds, bit N of the trial difference is the borrow.
    always_comb begin
        mul_sum   = acc_q + (q_q[0] ? {1'b0, b_q} : '0);
        div_shift = {acc_q[N-1:0], q_q[N-1]};
        div_diff  = div_shift - {1'b0, b_q};
        if (is_div_q) begin
            step_acc = {1'b0, div_diff[N] ? div_shift[N-1:0] : div_diff[N-1:0]};
            step_q   = {q_q[N-2:0], ~div_diff[N]};
        end else begin
            step_acc = {1'b0, mul_sum[N:1]};
            step_q   = {mul_sum[0], q_q[N-1:1]};
        end
    end

    always_comb begin
        prod    = {step_acc[N-1:0], step_q};
        res_dbz = 1'b0;
`ifdef MDU_SIGNED_EN
        if (neg_q) begin
            prod = -prod;
        end
`endif
        res_hi = prod[2*N-1:N];
        res_lo = prod[N-1:0];
        if (is_div_q) begin
            res_hi = step_acc[N-1:0];
            res_lo = step_q;
`ifdef MDU_SIGNED_EN
            if (neg_q) begin
                res_lo = -step_q;
            end
            if (negr_q) begin
                res_hi = -step_acc[N-1:0];
            end
`endif
            // A zero divisor reports the untouched dividend rather than the iteration result.
            if (b_q == '0) begin
                res_hi  = dvd_q;
                res_lo  = '1;
                res_dbz = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        acc_d    = acc_q;
        q_d      = q_q;
        b_d      = b_q;
        dvd_d    = dvd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;
`ifdef MDU_SIGNED_EN
        neg_d    = neg_q;
        negr_d   = negr_q;
`endif
        case (state_q)
            RUN: begin
                acc_d = step_acc;
                q_d   = step_q;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = FINISH;
                    cnt_d   = '0;
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    dbz_d   = res_dbz;
                end
            end
            default: begin
                state_d = IDLE;
                if (start_i) begin
                    state_d  = RUN;
                    cnt_d    = '0;
                    is_div_d = op_i[0];
                    acc_d    = '0;
                    q_d      = mag_a;
                    b_d      = mag_b;
                    dvd_d    = rs_data_i;
`ifdef MDU_SIGNED_EN
                    neg_d    = sign_a ^ sign_b;
                    negr_d   = sign_a;
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            acc_q    <= '0;
            q_q      <= '0;
            b_q      <= '0;
            dvd_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
`ifdef MDU_SIGNED_EN
            neg_q    <= 1'b0;
            negr_q   <= 1'b0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            b_q      <= b_d;
            dvd_q    <= dvd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dbz_q    <= dbz_d;
`ifdef MDU_SIGNED_EN
            neg_q    <= neg_d;
            negr_q   <= negr_d;
`endif
        end
    end

    assign busy_o        = (state_q == RUN);
    assign done_o        = (state_q == FINISH);
    assign div_by_zero_o = dbz_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: issued ops push reference results, a monitor checks each done_o.
module tb_mult_div_unit;

    localparam int N = 32;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] rs_data_i, rt_data_i;
    logic        busy_o, done_o, div_by_zero_o;
    logic [31:0] hi_o, lo_o;

    int          checks = 0;
    int          errors = 0;
    exp_t        scb[$];
    exp_t        mon_e;
    logic [31:0] last_hi = '0, last_lo = '0;
    time         t_done;

    mult_div_unit #(.N(N)) dut (
        .clk(clk), .reset(rst_n), .start_i(start_i), .op_i(op_i),
        .rs_data_i(rs_data_i), .rt_data_i(rt_data_i),
        .busy_o(busy_o), .done_o(done_o), .div_by_zero_o(div_by_zero_o),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the operands as the ISA defines them.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] p;
        longint      sa, sbv, q, r;
        bit          sgn;
        sgn = 1'b0;
`ifdef MDU_SIGNED_EN
        sgn = op[1];
`endif
        sa  = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        sbv = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        e.dbz = 1'b0;
        if (!op[0]) begin
            p = sa * sbv;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (b == 32'd0) begin
            e.hi  = a;
            e.lo  = 32'hFFFF_FFFF;
            e.dbz = 1'b1;
        end else begin
            q = sa / sbv;
            r = sa % sbv;
            p = q;
            e.lo = p[31:0];
            p = r;
            e.hi = p[31:0];
        end
        return e;
    endfunction

    // Issues one op in the current cycle and follows it until done_o (bounded).
    // Returns #1 after the done edge, so a following call starts back-to-back.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int poke, input bit use_c,
                          input logic [31:0] chi, input logic [31:0] clo, input logic cdbz);
        exp_t e;
        int   lat, bcnt;
        bit   hold_ok, seen;
        if (use_c) e = '{hi: chi, lo: clo, dbz: cdbz};
        else       e = model(op, a, b);
        op_i = op; rs_data_i = a; rt_data_i = b; start_i = 1'b1;
        scb.push_back(e);
        @(posedge clk); #1;
        start_i = 1'b0; rs_data_i = $urandom; rt_data_i = $urandom; op_i = 2'($urandom_range(0, 3));
        lat = 1; bcnt = 0; hold_ok = 1'b1; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done_o) begin
                seen = 1'b1;
            end else begin
                if (busy_o) bcnt++;
                if (hi_o !== last_hi || lo_o !== last_lo) hold_ok = 1'b0;
                if (i == poke) begin
                    start_i = 1'b1; rs_data_i = $urandom; rt_data_i = $urandom;
                end
                @(posedge clk); #1;
                start_i = 1'b0;
                lat++;
            end
        end
        t_done = $time;
        chk("done_seen", 64'(seen), 64'd1);
        chk("latency", 64'(lat), 64'(N + 1));
        chk("busy_cycles", 64'(bcnt), 64'(N));
        chk("result_hold", 64'(hold_ok), 64'd1);
        if (seen) chk("busy_in_done", 64'(busy_o), 64'd0);
        last_hi = e.hi;
        last_lo = e.lo;
    endtask

    always @(negedge clk) begin
        if (rst_n && done_o) begin
            if (scb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = scb.pop_front();
                chk("hi", 64'(hi_o), 64'(mon_e.hi));
                chk("lo", 64'(lo_o), 64'(mon_e.lo));
                chk("div_by_zero", 64'(div_by_zero_o), 64'(mon_e.dbz));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        time t1;
        int  ndone;
        rst_n = 1'b0; start_i = 1'b0; op_i = 2'd0; rs_data_i = '0; rt_data_i = '0;
        #23;
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_dbz", 64'(div_by_zero_o), 64'd0);
        chk("rst_hi", 64'(hi_o), 64'd0);
        chk("rst_lo", 64'(lo_o), 64'd0);
        #9 rst_n = 1'b1;

        // MULTU max*max, DIVU with an ignored mid-op start, DIVU by zero
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        run_op(2'b01, 32'd100, 32'd7, 10, 1'b1, 32'd2, 32'd14, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_no_done", 64'(done_o), 64'd0);
        chk("idle_hold_lo", 64'(lo_o), 64'(last_lo));
        run_op(2'b01, 32'h1234, 32'd0, -1, 1'b1, 32'h1234, 32'hFFFF_FFFF, 1'b1);
        @(posedge clk); #1;
        chk("dbz_held", 64'(div_by_zero_o), 64'd1);

        // Reset mid-operation aborts without done
        op_i = 2'b00; rs_data_i = 32'd3; rt_data_i = 32'd5; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy_o), 64'd0);
        chk("abort_done", 64'(done_o), 64'd0);
        chk("abort_dbz", 64'(div_by_zero_o), 64'd0);
        chk("abort_hi", 64'(hi_o), 64'd0);
        chk("abort_lo", 64'(lo_o), 64'd0);
        scb.delete();
        last_hi = '0; last_lo = '0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done_o) ndone++;
        end
        chk("abort_no_done", 64'(ndone), 64'd0);
        run_op(2'b00, 32'd3, 32'd5, -1, 1'b1, 32'd0, 32'd15, 1'b0);

        // Back-to-back: next start during the done cycle, previous result held meanwhile
        run_op(2'b01, 32'd1000, 32'd33, -1, 1'b0, '0, '0, 1'b0);
        t1 = t_done;
        run_op(2'b00, 32'h1234_5678, 32'h0000_0010, -1, 1'b0, '0, '0, 1'b0);
        chk("b2b_spacing", 64'((t_done - t1) / 10), 64'(N + 1));

`ifdef MDU_SIGNED_EN
        run_op(2'b10, 32'hFFFF_FFFD, 32'd7, -1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, -1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b1, 32'h0, 32'h8000_0000, 1'b0);
        run_op(2'b11, 32'hFFFF_FFF9, 32'd0, -1, 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
`else
        run_op(2'b10, 32'hFFFF_FFFD, 32'd7, -1, 1'b1, 32'h6, 32'hFFFF_FFEB, 1'b0);
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, -1, 1'b1, 32'h1, 32'h7FFF_FFFC, 1'b0);
`endif

        // Randomized ops, divisors biased toward zero and small values, random gaps
        for (int k = 0; k < 24; k++) begin
            logic [1:0]  rop;
            logic [31:0] ra, rb;
            int          kind, gap, pk;
            rop  = 2'($urandom_range(0, 3));
            ra   = $urandom;
            kind = $urandom_range(0, 3);
            rb   = (kind == 0) ? 32'd0 : (kind == 1) ? 32'($urandom_range(1, 15)) : $urandom;
            pk   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, N - 3) : -1;
            run_op(rop, ra, rb, pk, 1'b0, '0, '0, 1'b0);
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
                chk("gap_no_done", 64'(done_o), 64'd0);
                chk("gap_hold_hi", 64'(hi_o), 64'(last_hi));
            end
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(scb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
